control_panel: RTL

Front-panel input conditioner for the uniciclo LEGv8 board. Debounces the four raw push-buttons into clean, press-active-high key levels and maintains the 8-bit clock divisor. Raises a single break pulse when the processor PC hits a programmed breakpoint and arms the 10-second timer. It sits between the board pins / processor datapath and the clock interface, driving that block's key, `fdiv`, timer and break inputs.

---
 rtl/control_panel_pkg.sv | 15 +
 rtl/key_debounce.sv | 80 ++++++++
 rtl/control_panel.sv | 129 ++++++++++++
 3 files changed

// File: rtl/control_panel_pkg.sv
// rtl/control_panel_pkg.sv - shared types and constants for the front-panel conditioner
package control_panel_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } deb_state_t;

    localparam logic [7:0] FDIV_MIN   = 8'd1;
    localparam logic [7:0] FDIV_MAX   = 8'd255;
    localparam int         SYNC_DEPTH = 2;

endpackage

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - synchronizer, debounce FSM and stability counter for one push-button
module key_debounce
    import control_panel_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    output logic key
);

    localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    // The entry sample into a wait state is stable sample number one, so
    // acceptance happens when the counter would step onto DEBOUNCE_CYCLES-1.
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 2);

    logic [SYNC_DEPTH-1:0] sync;
    logic                  sample;
    deb_state_t            state, state_next;
    logic [CW-1:0]         cnt, cnt_next;

    assign sample = sync[SYNC_DEPTH-1];

    // Synchronizer, state and counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync  <= '0;
            state <= IDLE;
            cnt   <= '0;
        end else begin
            sync  <= {sync[SYNC_DEPTH-2:0], ~key_n};
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Next-state and counter update; any bounce falls back to the stable state
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            IDLE: begin
                if (sample) begin
                    state_next = PRESS_WAIT;
                    cnt_next   = '0;
                end
            end
            PRESS_WAIT: begin
                if (!sample)
                    state_next = IDLE;
                else if (cnt == CNT_LAST)
                    state_next = PRESSED;
                else
                    cnt_next = cnt + CW'(1);
            end
            PRESSED: begin
                if (!sample) begin
                    state_next = RELEASE_WAIT;
                    cnt_next   = '0;
                end
            end
            RELEASE_WAIT: begin
                if (sample)
                    state_next = PRESSED;
                else if (cnt == CNT_LAST)
                    state_next = IDLE;
                else
                    cnt_next = cnt + CW'(1);
            end
            default: state_next = IDLE;
        endcase
    end

    // Key level is high while the press is accepted, including release qualification
    always_comb begin
        key = (state == PRESSED) || (state == RELEASE_WAIT);
    end

endmodule

// File: rtl/control_panel.sv
// rtl/control_panel.sv - key debounce, clock divisor, timer, breakpoint pulse; CONTROL_PANEL_CYCLE_COUNTER_EN adds the CPU cycle counter
module control_panel
    import control_panel_pkg::*;
#(
    parameter int         DEBOUNCE_CYCLES = 500000,
    parameter logic [7:0] FDIV_RESET      = 8'd1,
    parameter int         BREAK_PULSE     = 4
) (
    input  logic        iCLK_50,
    input  logic        iRST,
    input  logic [3:0]  iKEY,
    input  logic        iDivDown,
    input  logic        iTimerSw,
    input  logic [63:0] iPC,
    input  logic [63:0] iBreakAddr,
    input  logic        iBreakEn,
    input  logic        iCPU_CLK,
    output logic [3:0]  oKEY,
    output logic [7:0]  oFdiv,
    output logic        oTimer,
    output logic        oBreak,
    output logic [31:0] oCycles
);

    localparam int BW = (BREAK_PULSE > 1) ? $clog2(BREAK_PULSE) : 1;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_key
            key_debounce #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_key (
                .clk  (iCLK_50),
                .rst_n(iRST),
                .key_n(iKEY[gi]),
                .key  (oKEY[gi])
            );
        end
    endgenerate

    logic                  key0_q;
    logic [7:0]            fdiv;
    logic [SYNC_DEPTH-1:0] timer_sync;
    logic                  match_q;
    logic                  match_prev;
    logic                  brk;
    logic [BW-1:0]         brk_cnt;

    // Divisor steps once per accepted KEY0 press, saturating at both ends
    always_ff @(posedge iCLK_50 or negedge iRST) begin
        if (!iRST) begin
            key0_q <= 1'b0;
            fdiv   <= FDIV_RESET;
        end else begin
            key0_q <= oKEY[0];
            if (oKEY[0] && !key0_q) begin
                if (iDivDown) begin
                    if (fdiv > FDIV_MIN)
                        fdiv <= fdiv - 8'd1;
                end else if (fdiv < FDIV_MAX) begin
                    fdiv <= fdiv + 8'd1;
                end
            end
        end
    end

    // Timer switch synchronizer drives the timer enable directly
    always_ff @(posedge iCLK_50 or negedge iRST) begin
        if (!iRST)
            timer_sync <= '0;
        else
            timer_sync <= {timer_sync[SYNC_DEPTH-2:0], iTimerSw};
    end

    // Registered breakpoint compare; a rising match launches a fixed-width pulse
    always_ff @(posedge iCLK_50 or negedge iRST) begin
        if (!iRST) begin
            match_q    <= 1'b0;
            match_prev <= 1'b0;
            brk        <= 1'b0;
            brk_cnt    <= '0;
        end else begin
            match_q    <= iBreakEn && (iPC == iBreakAddr);
            match_prev <= match_q;
            if (match_q && !match_prev) begin
                brk     <= 1'b1;
                brk_cnt <= BW'(BREAK_PULSE - 1);
            end else if (brk) begin
                if (brk_cnt == '0)
                    brk <= 1'b0;
                else
                    brk_cnt <= brk_cnt - BW'(1);
            end
        end
    end

    assign oFdiv  = fdiv;
    assign oTimer = timer_sync[SYNC_DEPTH-1];
    assign oBreak = brk;

`ifdef CONTROL_PANEL_CYCLE_COUNTER_EN
    logic [SYNC_DEPTH-1:0] cpu_sync;
    logic                  cpu_q;
    logic [31:0]           cycles;

    // Count synchronized CPU clock rising edges; KEY3+KEY2 together clear the count
    always_ff @(posedge iCLK_50 or negedge iRST) begin
        if (!iRST) begin
            cpu_sync <= '0;
            cpu_q    <= 1'b0;
            cycles   <= '0;
        end else begin
            cpu_sync <= {cpu_sync[SYNC_DEPTH-2:0], iCPU_CLK};
            cpu_q    <= cpu_sync[SYNC_DEPTH-1];
            if (oKEY[3] && oKEY[2])
                cycles <= '0;
            else if (cpu_sync[SYNC_DEPTH-1] && !cpu_q)
                cycles <= cycles + 32'd1;
        end
    end

    assign oCycles = cycles;
`else
    logic unused_cpu_clk;
    assign unused_cpu_clk = iCPU_CLK;
    assign oCycles        = '0;
`endif

endmodule
